// File: rtl/fma_dot_pkg.sv
// Shared types and fixed-point constants for the fma dot-product sequencer.
package fma_dot_pkg;

  localparam int unsigned FMA_Q = 15;
  localparam int unsigned FMA_N = 32;

  localparam logic [FMA_N-1:0] FX_ONE  = {{(FMA_N-1){1'b0}}, 1'b1} << FMA_Q;
  localparam logic [FMA_N-1:0] FX_SIGN = {1'b1, {(FMA_N-1){1'b0}}};

  // Encodings kept identical to the legacy localparam values.
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  typedef enum logic [1:0] {
    IDLE = ST_IDLE,
    RUN  = ST_RUN,
    DONE = ST_DONE
  } fma_dot_state_t;

endpackage

// File: rtl/fma.sv
// Combinational sign-magnitude fixed-point fused multiply-add: o_y = i_a + i_b*i_c.
// Product truncated to Q fractional bits; magnitudes wrap, no saturation.
module fma #(
  parameter int unsigned Q = 15,
  parameter int unsigned N = 32
) (
  input  logic [N-1:0] i_a,
  input  logic [N-1:0] i_b,
  input  logic [N-1:0] i_c,
  output logic [N-1:0] o_y
);

  logic [2*N-3:0] w_prod;
  logic [N-2:0]   w_mp;
  logic [N-2:0]   w_ma;
  logic [N-2:0]   w_mag;
  logic           w_sa;
  logic           w_sp;
  logic           w_sgn;

  assign w_sa   = i_a[N-1];
  assign w_ma   = i_a[N-2:0];
  assign w_sp   = i_b[N-1] ^ i_c[N-1];
  assign w_prod = {{(N-1){1'b0}}, i_b[N-2:0]} * {{(N-1){1'b0}}, i_c[N-2:0]};
  assign w_mp   = (N-1)'(w_prod >> Q);

  always_comb begin
    w_mag = '0;
    w_sgn = 1'b0;
    if (w_sa == w_sp) begin
      w_mag = w_ma + w_mp;
      w_sgn = w_sa;
    end else if (w_ma >= w_mp) begin
      w_mag = w_ma - w_mp;
      w_sgn = w_sa;
    end else begin
      w_mag = w_mp - w_ma;
      w_sgn = w_sp;
    end
  end

  // A zero magnitude is always reported as +0.
  assign o_y = {w_sgn & (|w_mag), w_mag};

endmodule

// File: rtl/fma_dot_seq.sv
// Biased dot-product sequencer time-sharing one fma instance per accepted beat.
// Optional FMA_DOT_ABORT_EN adds an abort input that returns the block to IDLE.
module fma_dot_seq
  import fma_dot_pkg::*;
#(
  parameter int unsigned Q     = 15,
  parameter int unsigned N     = 32,
  parameter int unsigned LEN_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  input  logic [N-1:0]     bias,
  input  logic             x_valid,
  output logic             x_ready,
  input  logic [N-1:0]     x_data,
  input  logic [N-1:0]     w_data,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [N-1:0]     res_data,
  output logic             busy
`ifdef FMA_DOT_ABORT_EN
  ,
  input  logic             abort
`endif
);

  fma_dot_state_t   r_state;
  logic [N-1:0]     r_acc;
  logic [LEN_W-1:0] r_cnt;
  logic [N-1:0]     w_fma;
  logic             w_abort;

`ifdef FMA_DOT_ABORT_EN
  assign w_abort = abort;
`else
  assign w_abort = 1'b0;
`endif

  fma #(.Q(Q), .N(N)) u_fma (
    .i_a (r_acc),
    .i_b (x_data),
    .i_c (w_data),
    .o_y (w_fma)
  );

  assign x_ready   = (r_state == RUN);
  assign res_valid = (r_state == DONE);
  assign busy      = (r_state != IDLE);
  assign res_data  = (r_state == DONE) ? r_acc : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_acc   <= '0;
      r_cnt   <= '0;
    end else if (w_abort && (r_state != IDLE)) begin
      r_state <= IDLE;
      r_acc   <= '0;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          // abort in IDLE suppresses a same-cycle start.
          if (start && !w_abort) begin
            r_acc <= bias;
            if (len != '0) begin
              r_cnt   <= len;
              r_state <= RUN;
            end else begin
              r_state <= DONE;
            end
          end
        end
        RUN: begin
          if (x_valid) begin
            r_acc <= w_fma;
            r_cnt <= r_cnt - 1'b1;
            if (r_cnt == {{(LEN_W-1){1'b0}}, 1'b1}) begin
              r_state <= DONE;
            end
          end
        end
        DONE: begin
          if (res_ready) begin
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule
